// File: rtl/hazard_dual.sv
// Hazard and forwarding control for the dual-issue pipeline: per-lane operand
// forwarding selects, load-use detection and a multiply-wait stall machine.
module hazard_dual #(
  parameter int MULT_TIMEOUT = 64,
  parameter int CNT_W        = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rsd,
  input  logic [4:0] rtd,
  input  logic [4:0] rsd2,
  input  logic [4:0] rtd2,
  input  logic [4:0] rse,
  input  logic [4:0] rte,
  input  logic [4:0] rse2,
  input  logic [4:0] rte2,
  input  logic [4:0] writerege,
  input  logic [4:0] writerege2,
  input  logic [4:0] writeregm,
  input  logic [4:0] writeregm2,
  input  logic [4:0] writeregw,
  input  logic [4:0] writeregw2,
  input  logic       regwritee,
  input  logic       regwritee2,
  input  logic       regwritem,
  input  logic       regwritem2,
  input  logic       regwritew,
  input  logic       regwritew2,
  input  logic       memtorege,
  input  logic       memtorege2,
  input  logic       multsele,
  input  logic       multsele2,
  input  logic       multready,
  input  logic       multready2,
  output logic [2:0] forwardae,
  output logic [2:0] forwardbe,
  output logic [2:0] forwardae2,
  output logic [2:0] forwardbe2,
  output logic       stallf,
  output logic       stalld,
  output logic       stalle,
  output logic       flushe,
  output logic       multbusy,
  output logic       multtimeout
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_TIMEOUT - 1);

  // A producer matches only when it writes, and register 0 never matches.
  function automatic logic hit(input logic we, input logic [4:0] dst, input logic [4:0] src);
    return we && (src != 5'd0) && (dst == src);
  endfunction

  function automatic logic [2:0] sel_lane0(input logic m2, input logic m,
                                           input logic w2, input logic w);
    if (m2)      return 3'd3;
    else if (m)  return 3'd2;
    else if (w2) return 3'd4;
    else if (w)  return 3'd1;
    else         return 3'd0;
  endfunction

  // Lane 1 sees lane 0's E result as the youngest producer in the bundle.
  function automatic logic [2:0] sel_lane1(input logic e, input logic m2, input logic m,
                                           input logic w2, input logic w);
    if (e)       return 3'd3;
    else if (m2) return 3'd2;
    else if (m)  return 3'd4;
    else if (w2) return 3'd1;
    else if (w)  return 3'd5;
    else         return 3'd0;
  endfunction

  assign forwardae = sel_lane0(hit(regwritem2, writeregm2, rse), hit(regwritem, writeregm, rse),
                               hit(regwritew2, writeregw2, rse), hit(regwritew, writeregw, rse));
  assign forwardbe = sel_lane0(hit(regwritem2, writeregm2, rte), hit(regwritem, writeregm, rte),
                               hit(regwritew2, writeregw2, rte), hit(regwritew, writeregw, rte));
  assign forwardae2 = sel_lane1(hit(regwritee, writerege, rse2),
                                hit(regwritem2, writeregm2, rse2), hit(regwritem, writeregm, rse2),
                                hit(regwritew2, writeregw2, rse2), hit(regwritew, writeregw, rse2));
  assign forwardbe2 = sel_lane1(hit(regwritee, writerege, rte2),
                                hit(regwritem2, writeregm2, rte2), hit(regwritem, writeregm, rte2),
                                hit(regwritew2, writeregw2, rte2), hit(regwritew, writeregw, rte2));

  logic ld0_use, ld1_use, ld0_bundle, lwstall;

  assign ld0_use = hit(memtorege, writerege, rsd)  || hit(memtorege, writerege, rtd) ||
                   hit(memtorege, writerege, rsd2) || hit(memtorege, writerege, rtd2);
  assign ld1_use = hit(memtorege2, writerege2, rsd)  || hit(memtorege2, writerege2, rtd) ||
                   hit(memtorege2, writerege2, rsd2) || hit(memtorege2, writerege2, rtd2);
  // A lane 0 load cannot feed lane 1 of the same bundle through solutione.
  assign ld0_bundle = hit(memtorege, writerege, rse2) || hit(memtorege, writerege, rte2);
  assign lwstall = ld0_use || ld1_use || ld0_bundle;

  state_t           state, state_next;
  logic [1:0]       pending, pending_next, pending_clr;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             timeout_next;
  logic             mstall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pending     <= 2'b00;
      cnt         <= '0;
      multtimeout <= 1'b0;
    end else begin
      state       <= state_next;
      pending     <= pending_next;
      cnt         <= cnt_next;
      multtimeout <= timeout_next;
    end
  end

  assign pending_clr = pending & ~{multready2, multready};

  always_comb begin
    state_next   = state;
    pending_next = pending;
    cnt_next     = cnt;
    timeout_next = multtimeout;
    mstall       = 1'b0;
    case (state)
      IDLE: begin
        if (multsele || multsele2) begin
          mstall       = 1'b1;
          state_next   = WAIT;
          pending_next = {multsele2, multsele};
          cnt_next     = '0;
        end
      end
      WAIT: begin
        if (pending_clr == 2'b00) begin
          state_next   = IDLE;
          pending_next = 2'b00;
        end else if (cnt == CNT_LAST) begin
          // Give up on a stuck multiplier and record it until reset.
          state_next   = IDLE;
          pending_next = 2'b00;
          timeout_next = 1'b1;
        end else begin
          pending_next = pending_clr;
          cnt_next     = cnt + CNT_W'(1);
          mstall       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign stallf   = mstall || lwstall;
  assign stalld   = mstall || lwstall;
  assign stalle   = mstall;
  assign flushe   = lwstall && !mstall;
  assign multbusy = (state == WAIT);

endmodule

// File: tb/tb_hazard_dual.sv
// Directed bench for hazard_dual: forwarding priority, load-use, multiply
// wait (single, dual, timeout) and reset recovery, with hand-computed values.
module tb_hazard_dual;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rsd, rtd, rsd2, rtd2, rse, rte, rse2, rte2;
  logic [4:0] writerege, writerege2, writeregm, writeregm2, writeregw, writeregw2;
  logic       regwritee, regwritee2, regwritem, regwritem2, regwritew, regwritew2;
  logic       memtorege, memtorege2, multsele, multsele2, multready, multready2;
  logic [2:0] forwardae, forwardbe, forwardae2, forwardbe2;
  logic       stallf, stalld, stalle, flushe, multbusy, multtimeout;

  int checks   = 0;
  int failures = 0;

  hazard_dual #(.MULT_TIMEOUT(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .rsd(rsd), .rtd(rtd), .rsd2(rsd2), .rtd2(rtd2),
    .rse(rse), .rte(rte), .rse2(rse2), .rte2(rte2),
    .writerege(writerege), .writerege2(writerege2),
    .writeregm(writeregm), .writeregm2(writeregm2),
    .writeregw(writeregw), .writeregw2(writeregw2),
    .regwritee(regwritee), .regwritee2(regwritee2),
    .regwritem(regwritem), .regwritem2(regwritem2),
    .regwritew(regwritew), .regwritew2(regwritew2),
    .memtorege(memtorege), .memtorege2(memtorege2),
    .multsele(multsele), .multsele2(multsele2),
    .multready(multready), .multready2(multready2),
    .forwardae(forwardae), .forwardbe(forwardbe),
    .forwardae2(forwardae2), .forwardbe2(forwardbe2),
    .stallf(stallf), .stalld(stalld), .stalle(stalle), .flushe(flushe),
    .multbusy(multbusy), .multtimeout(multtimeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {rsd, rtd, rsd2, rtd2, rse, rte, rse2, rte2} = '0;
    {writerege, writerege2, writeregm, writeregm2, writeregw, writeregw2} = '0;
    {regwritee, regwritee2, regwritem, regwritem2, regwritew, regwritew2} = '0;
    {memtorege, memtorege2, multsele, multsele2, multready, multready2} = '0;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    #1;
    check("rst_stallf", 32'(stallf), 32'd0);
    check("rst_stalle", 32'(stalle), 32'd0);
    check("rst_flushe", 32'(flushe), 32'd0);
    check("rst_busy", 32'(multbusy), 32'd0);
    check("rst_tmo", 32'(multtimeout), 32'd0);
    check("rst_fwd", 32'({forwardae, forwardbe, forwardae2, forwardbe2}), 32'd0);
    reset = 1'b0;
    tick();

    // Lane 0 forwarding priority
    rse = 5'd5; writeregm2 = 5'd5; writeregm = 5'd5; writeregw = 5'd5;
    {regwritee, regwritee2, regwritem, regwritem2, regwritew, regwritew2} = '1;
    #1 check("fa_m2", 32'(forwardae), 32'd3);
    regwritem2 = 1'b0;
    #1 check("fa_m", 32'(forwardae), 32'd2);
    regwritem = 1'b0; writeregw2 = 5'd5;
    #1 check("fa_w2", 32'(forwardae), 32'd4);
    rse = 5'd0;
    #1 check("fa_zero", 32'(forwardae), 32'd0);
    rte = 5'd5; regwritew2 = 1'b0;
    #1 check("fb_w", 32'(forwardbe), 32'd1);
    clear_inputs();

    // Lane 1 forwarding priority
    rse2 = 5'd7; writerege = 5'd7; writeregm = 5'd7; regwritee = 1'b1; regwritem = 1'b1;
    #1 check("fa2_e", 32'(forwardae2), 32'd3);
    regwritee = 1'b0;
    #1 check("fa2_m", 32'(forwardae2), 32'd4);
    regwritem = 1'b0; rte2 = 5'd7; writeregw = 5'd7; regwritew = 1'b1;
    #1 check("fb2_w", 32'(forwardbe2), 32'd5);
    check("fa2_w", 32'(forwardae2), 32'd5);
    clear_inputs();

    // Load-use and intra-bundle load
    memtorege = 1'b1; writerege = 5'd9; rtd2 = 5'd9;
    #1;
    check("lu_stallf", 32'(stallf), 32'd1);
    check("lu_stalld", 32'(stalld), 32'd1);
    check("lu_flushe", 32'(flushe), 32'd1);
    check("lu_stalle", 32'(stalle), 32'd0);
    rtd2 = 5'd0; rte2 = 5'd9;
    #1 check("lb_stallf", 32'(stallf), 32'd1);
    writerege = 5'd0; rte2 = 5'd0; rsd = 5'd0;
    #1 check("lu_r0", 32'(stallf), 32'd0);
    clear_inputs();

    // Single multiply, ready in cycle 4
    multsele = 1'b1;
    #1 check("m1_c0_stall", 32'(stalle), 32'd1);
    check("m1_c0_busy", 32'(multbusy), 32'd0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      multready = (c == 4);
      #1;
      check($sformatf("m1_c%0d_stall", c), 32'(stalle), (c < 4) ? 32'd1 : 32'd0);
      check($sformatf("m1_c%0d_busy", c), 32'(multbusy), 32'd1);
    end
    tick();
    multsele = 1'b0; multready = 1'b0;
    #1 check("m1_c5_busy", 32'(multbusy), 32'd0);
    check("m1_c5_stall", 32'(stallf), 32'd0);

    // Dual multiply, ready in 3, ready2 in 6
    tick();
    multsele = 1'b1; multsele2 = 1'b1;
    #1 check("m2_c0_stall", 32'(stallf), 32'd1);
    for (int c = 1; c <= 6; c++) begin
      tick();
      multready  = (c == 3);
      multready2 = (c == 6);
      #1;
      check($sformatf("m2_c%0d_stall", c), 32'(stallf), (c < 6) ? 32'd1 : 32'd0);
      check($sformatf("m2_c%0d_busy", c), 32'(multbusy), 32'd1);
    end
    tick();
    clear_inputs();
    #1 check("m2_c7_busy", 32'(multbusy), 32'd0);

    // Multiply with load-use in the same cycle: hold, no flush
    tick();
    multsele = 1'b1; memtorege = 1'b1; writerege = 5'd3; rsd = 5'd3;
    #1;
    check("ml_stallf", 32'(stallf), 32'd1);
    check("ml_stalle", 32'(stalle), 32'd1);
    check("ml_flushe", 32'(flushe), 32'd0);
    tick();
    memtorege = 1'b0; multready = 1'b1;
    #1 check("ml_rel", 32'(stalle), 32'd0);
    tick();
    clear_inputs();

    // Reset in the middle of a wait
    multsele = 1'b1;
    tick();
    tick();
    #1 check("rw_busy", 32'(multbusy), 32'd1);
    multsele = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    #1 check("rw_idle", 32'(multbusy), 32'd0);
    check("rw_stall", 32'(stalle), 32'd0);

    // Timeout with MULT_TIMEOUT = 8
    tick();
    multsele = 1'b1;
    #1 check("to_c0_stall", 32'(stalle), 32'd1);
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 9) multsele = 1'b0;
      #1;
      check($sformatf("to_c%0d_stall", c), 32'(stalle), (c < 8) ? 32'd1 : 32'd0);
      check($sformatf("to_c%0d_tmo", c), 32'(multtimeout), (c >= 9) ? 32'd1 : 32'd0);
      check($sformatf("to_c%0d_busy", c), 32'(multbusy), (c <= 8) ? 32'd1 : 32'd0);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1 check("to_reset", 32'(multtimeout), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
